cache_fill_fsm: RTL and testbench
=================================

// Module: cache_fill_fsm
// PURPOSE
//  Miss-handling state machine paired with each cache_controller instance.
//  On a cache miss it fetches the whole block from pipelined main memory,
//  word by word. It writes each returned word into the cache data array,
//  then writes the tag with the last word.
//  Its outputs drive the controller's miss_fixing, memory_address,
//  memory_data, memory_data_write and memory_tag_write inputs.
// PARAMETERS
//  ADDR_W      16  address width in bits
//  DATA_W      16  data word width in bits
//  WORDS       8   words per cache block (power of 2); word = 2 bytes
//  OFFSET_W    4   byte-offset bits in a block; equals log2(WORDS*2)
// PORTS
//  clk               in   1       system clock, rising edge
//  rst_n             in   1       asynchronous active-low reset
//  miss_detected     in   1       cache reports a miss this cycle (level)
//  miss_address      in   ADDR_W  CPU address that missed
//  memory_data_valid in   1       memory returns a read word this cycle
//  memory_data_in    in   DATA_W  word returned by memory
//  fsm_busy          out  1       fill in progress; drives miss_fixing and stalls the CPU
//  memory_enable     out  1       issue a read to memory this cycle
//  memory_address    out  ADDR_W  address of the issued memory read
//  cache_address     out  ADDR_W  cache word address for the returning data
//  memory_data       out  DATA_W  returning word forwarded to the cache
//  write_data_array  out  1       write memory_data at cache_address
//  write_tag_array   out  1       write tag/valid for the block (last word only)
//  fill_done         out  1       one-cycle pulse: block fill complete
// BEHAVIOUR
//  Reset: all outputs are 0, state IDLE, counters 0, base 0. Reset is async
//   and can occur mid-fill: the fill is abandoned with no further writes.
//  States:
//   IDLE -> FILL when miss_detected=1. Latch base = miss_address with the
//    low OFFSET_W bits cleared. Clear issue_cnt and recv_cnt.
//   FILL -> IDLE in the cycle memory_data_valid=1 and recv_cnt==WORDS-1.
//  FILL, issue side: while issue_cnt<WORDS, one read per cycle.
//   memory_enable=1, memory_address = base | (issue_cnt<<1), then issue_cnt++.
//   The first issue is in the cycle after entering FILL.
//   Once WORDS reads are issued, memory_enable=0.
//  FILL, receive side: when memory_data_valid=1, for that cycle only:
//   write_data_array=1, cache_address = base | (recv_cnt<<1),
//   memory_data = memory_data_in, then recv_cnt++.
//   Outputs are combinational from the registered state and counters.
//   When memory_data_valid=0: write_data_array=0, cache_address=base.
//  Last word (recv_cnt==WORDS-1 with memory_data_valid=1): in the same cycle,
//   write_tag_array=1 and fill_done=1. fsm_busy is 0 from the next cycle.
//  fsm_busy=1 in every FILL cycle, including the last-write cycle.
//  Issue and receive may occur in the same cycle; the counters are independent.
//  Memory latency is unknown to the FSM; completion is driven only by valid.
//  Offset arithmetic uses only the OFFSET_W low bits, with no carry into the
//   tag/index. Base 0xFFF0 covers 0xFFF0..0xFFFE.
//  miss_detected is ignored while in FILL.
//  memory_data_valid is ignored in IDLE: no writes occur.
//  A miss in the cycle after fill_done starts a new fill normally.
// TESTING
//  1 Reset: rst_n=0 mid-FILL, at recv_cnt=3 -> same-cycle outputs all 0;
//    after release, state IDLE and no write_* pulses.
//  2 Miss 0x1236 with 4-cycle memory latency -> reads 0x1230,0x1232..0x123E
//    on 8 consecutive cycles. Writes at the same addresses, in order.
//    write_tag_array and fill_done only on the 0x123E write.
//    fsm_busy high for exactly 1+4+8 = 13 cycles.
//  3 Wrap: miss 0xFFFA -> addresses 0xFFF0..0xFFFE; none is 0x0000 or higher.
//  4 Gapped valid: valid held low for 3 cycles after word 4 -> no writes
//    during the gap; fill completes after 8 valids; fsm_busy stays 1 throughout.
//  5 Miss while busy: second miss at 0x4000 during FILL -> ignored; base stays.
//    Stray valid in IDLE -> no write_data_array pulse.
//  6 Back-to-back: new miss 0x2000 in the cycle after fill_done -> new fill
//    with base 0x2000 and correct ordering.

Source files
------------

// File: rtl/cache_fill_fsm_if.sv
// Miss-fill bus between the cache/memory side and cache_fill_fsm.
// The FSM connects through the slave modport; the cache/memory side uses master.
interface cache_fill_fsm_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [DATA_W-1:0] memory_data_in;
  logic              fsm_busy;
  logic              memory_enable;
  logic [ADDR_W-1:0] memory_address;
  logic [ADDR_W-1:0] cache_address;
  logic [DATA_W-1:0] memory_data;
  logic              write_data_array;
  logic              write_tag_array;
  logic              fill_done;

  modport slave (
    input  miss_detected, miss_address, memory_data_valid, memory_data_in,
    output fsm_busy, memory_enable, memory_address, cache_address,
           memory_data, write_data_array, write_tag_array, fill_done
  );

  modport master (
    output miss_detected, miss_address, memory_data_valid, memory_data_in,
    input  fsm_busy, memory_enable, memory_address, cache_address,
           memory_data, write_data_array, write_tag_array, fill_done
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: streams one block from pipelined memory into the
// cache data array word by word, writing the tag together with the last word.
module cache_fill_fsm #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WORDS    = 8,
  parameter int OFFSET_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_fill_fsm_if.slave  bus
);
  localparam int CNT_W = $clog2(WORDS);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  // One extra bit so issue_cnt can reach WORDS and stop issuing.
  logic [CNT_W:0]    issue_cnt_reg, issue_cnt_next;
  logic [CNT_W-1:0]  recv_cnt_reg, recv_cnt_next;

  logic [OFFSET_W-1:0] issue_off;
  logic [OFFSET_W-1:0] recv_off;
  logic                issue_open;
  logic                last_word;

  // Word offsets live only in the low OFFSET_W bits, so OR-ing them onto the
  // cleared base can never carry into the tag/index bits.
  assign issue_off  = OFFSET_W'({issue_cnt_reg[CNT_W-1:0], 1'b0});
  assign recv_off   = OFFSET_W'({recv_cnt_reg, 1'b0});
  assign issue_open = (issue_cnt_reg[CNT_W] == 1'b0);
  assign last_word  = (recv_cnt_reg == CNT_W'(WORDS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      issue_cnt_reg <= '0;
      recv_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      base_reg      <= base_next;
      issue_cnt_reg <= issue_cnt_next;
      recv_cnt_reg  <= recv_cnt_next;
    end
  end

  always_comb begin
    state_next           = state_reg;
    base_next            = base_reg;
    issue_cnt_next       = issue_cnt_reg;
    recv_cnt_next        = recv_cnt_reg;
    bus.fsm_busy         = 1'b0;
    bus.memory_enable    = 1'b0;
    bus.memory_address   = base_reg;
    bus.cache_address    = base_reg;
    bus.memory_data      = '0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    bus.fill_done        = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (bus.miss_detected) begin
          state_next     = FILL;
          base_next      = {bus.miss_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          issue_cnt_next = '0;
          recv_cnt_next  = '0;
        end
      end

      FILL: begin
        bus.fsm_busy = 1'b1;
        // Issue and receive are independent; memory latency is not tracked.
        if (issue_open) begin
          bus.memory_enable  = 1'b1;
          bus.memory_address = base_reg | {{(ADDR_W-OFFSET_W){1'b0}}, issue_off};
          issue_cnt_next     = issue_cnt_reg + 1'b1;
        end
        if (bus.memory_data_valid) begin
          bus.write_data_array = 1'b1;
          bus.cache_address    = base_reg | {{(ADDR_W-OFFSET_W){1'b0}}, recv_off};
          bus.memory_data      = bus.memory_data_in;
          recv_cnt_next        = recv_cnt_reg + 1'b1;
          if (last_word) begin
            bus.write_tag_array = 1'b1;
            bus.fill_done       = 1'b1;
            state_next          = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a queued-latency memory model feeds the
// DUT while expected reads/writes, queued at each miss, are popped and compared.
module tb_cache_fill_fsm;
  localparam int LAT = 5;  // issue cycle to data-valid cycle

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_fill_fsm_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  cache_fill_fsm #(.ADDR_W(16), .DATA_W(16), .WORDS(8), .OFFSET_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [15:0] addr; int due; } rd_t;
  typedef struct { logic [15:0] addr; logic [15:0] data; logic last; } wr_t;

  rd_t         pend[$];
  logic [15:0] exp_rd[$];
  wr_t         exp_wr[$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   valid_cnt = 0;
  int   gap_after = 0;
  int   gap_len = 0;
  int   gap_left = 0;
  logic exp_busy = 1'b0;
  logic fill_end = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC35A;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(bus.fsm_busy), 0);
    check({tag, "_men"},  32'(bus.memory_enable), 0);
    check({tag, "_madr"}, 32'(bus.memory_address), 0);
    check({tag, "_cadr"}, 32'(bus.cache_address), 0);
    check({tag, "_mdat"}, 32'(bus.memory_data), 0);
    check({tag, "_wda"},  32'(bus.write_data_array), 0);
    check({tag, "_wta"},  32'(bus.write_tag_array), 0);
    check({tag, "_done"}, 32'(bus.fill_done), 0);
  endtask

  task automatic cycle(input logic miss, input logic [15:0] maddr, input logic stray);
    logic        v;
    logic [15:0] d;
    wr_t         e;
    @(posedge clk);
    #1;
    v = 1'b0;
    d = '0;
    if (stray) begin
      v = 1'b1;
      d = 16'hDEAD;
    end else if (gap_left > 0) begin
      gap_left--;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      v = 1'b1;
      d = mem_word(pend[0].addr);
      void'(pend.pop_front());
      valid_cnt++;
      if (valid_cnt == gap_after) gap_left = gap_len;
    end
    bus.miss_detected     = miss;
    bus.miss_address      = maddr;
    bus.memory_data_valid = v;
    bus.memory_data_in    = d;
    #1;
    check("busy", 32'(bus.fsm_busy), 32'(exp_busy));
    if (bus.fsm_busy) busy_cnt++;
    if (bus.memory_enable) begin
      if (exp_rd.size() == 0) check("unexp_read", 1, 0);
      else check("rd_addr", 32'(bus.memory_address), 32'(exp_rd.pop_front()));
      pend.push_back('{addr: bus.memory_address, due: cyc + LAT});
    end
    check("wr_vs_valid", 32'(bus.write_data_array), 32'(v && exp_busy));
    fill_end = 1'b0;
    if (v && exp_busy) begin
      if (exp_wr.size() == 0) begin
        check("exp_wr_empty", 1, 0);
      end else begin
        e = exp_wr.pop_front();
        $display("write addr=%h data=%h tag=%0b done=%0b", bus.cache_address,
                 bus.memory_data, bus.write_tag_array, bus.fill_done);
        check("wr_addr", 32'(bus.cache_address), 32'(e.addr));
        check("wr_data", 32'(bus.memory_data), 32'(e.data));
        check("wr_tag",  32'(bus.write_tag_array), 32'(e.last));
        check("wr_done", 32'(bus.fill_done), 32'(e.last));
        fill_end = e.last;
      end
    end else begin
      check("tag_quiet",  32'(bus.write_tag_array), 0);
      check("done_quiet", 32'(bus.fill_done), 0);
    end
    exp_busy = exp_busy ? !fill_end : miss;
    cyc++;
  endtask

  task automatic queue_fill(input logic [15:0] a);
    logic [15:0] b;
    b = {a[15:4], 4'h0};
    for (int i = 0; i < 8; i++) begin
      exp_rd.push_back(b | 16'(i * 2));
      exp_wr.push_back('{addr: b | 16'(i * 2), data: mem_word(b | 16'(i * 2)), last: (i == 7)});
    end
    gap_left  = 0;
    valid_cnt = 0;
    busy_cnt  = 0;
    fill_end  = 1'b0;
  endtask

  task automatic run_fill(input logic [15:0] a, input int g_after, input int g_len,
                          input int intrude_at, input int exp_cycles);
    $display("miss addr=%h", a);
    queue_fill(a);
    gap_after = g_after;
    gap_len   = g_len;
    cycle(1'b1, a, 1'b0);
    for (int k = 0; k < 80 && !fill_end; k++) cycle(k == intrude_at, 16'h4000, 1'b0);
    if (!fill_end) begin
      check("fill_timeout", 0, 1);
      exp_busy = 1'b0;
    end
    if (exp_cycles > 0) check("busy_cycles", 32'(busy_cnt), 32'(exp_cycles));
    check("rd_left", 32'(exp_rd.size()), 0);
    check("wr_left", 32'(exp_wr.size()), 0);
    exp_rd.delete();
    exp_wr.delete();
    pend.delete();
  endtask

  initial begin
    bus.miss_detected     = 1'b0;
    bus.miss_address      = '0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data_in    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("por");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Nominal fill with one idle cycle before it.
    cycle(1'b0, 16'h0000, 1'b0);
    run_fill(16'h1236, 0, 0, -1, 13);
    cycle(1'b0, 16'h0000, 1'b0);

    // Offset wrap stays inside the top block.
    run_fill(16'hFFFA, 0, 0, -1, 13);
    cycle(1'b0, 16'h0000, 1'b0);

    // Valid gap of 3 cycles after the 4th word.
    run_fill(16'h3008, 4, 3, -1, 16);
    cycle(1'b0, 16'h0000, 1'b0);

    // Second miss during FILL is ignored; stray valids in IDLE write nothing.
    run_fill(16'h777C, 0, 0, 3, 13);
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0);

    // Back-to-back fills: new miss in the cycle after fill_done.
    run_fill(16'h1110, 0, 0, -1, 13);
    run_fill(16'h2000, 0, 0, -1, 13);
    cycle(1'b0, 16'h0000, 1'b0);

    // Asynchronous reset in the middle of a fill with recv_cnt at 3.
    $display("miss addr=5556 (reset mid-fill)");
    queue_fill(16'h5556);
    gap_after = 0;
    gap_len   = 0;
    cycle(1'b1, 16'h5556, 1'b0);
    for (int k = 0; k < 40 && valid_cnt < 3; k++) cycle(1'b0, 16'h0000, 1'b0);
    check("pre_reset_words", 32'(valid_cnt), 3);
    @(posedge clk);
    #1;
    bus.miss_detected     = 1'b1;
    bus.memory_data_valid = 1'b1;
    bus.memory_data_in    = 16'hBEEF;
    #1;
    check("pre_reset_wda", 32'(bus.write_data_array), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst");
    bus.miss_detected     = 1'b0;
    bus.memory_data_valid = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    pend.delete();
    exp_busy = 1'b0;
    cyc++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 16'h0000, 1'b0);
    repeat (2) cycle(1'b0, 16'h0000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
